// File: rtl/fifo_arb_pkg.sv
// ============================================================================
// Module      : fifo_arb_pkg
// Description : Shared types and the round-robin selection function for the
//               FIFO write-side arbiter and any future read-side scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

  // Arbiter state encoding: ARB = choose a producer, BUSY = stream its burst.
  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Largest supported producer count; the selector works on this width.
  localparam int MAX_REQ = 16;

  // Round-robin pick: rotate the request vector so that position last+1 is
  // scanned first, take the lowest set bit, and map it back to an absolute
  // index. Returns -1 when no request is set. 'last' must be below 'n'.
  function automatic int rr_next(input logic [MAX_REQ-1:0] req,
                                 input int                 last,
                                 input int                 n);
    int res;
    int k;
    res = -1;
    // Walk from the farthest rotated position down to the nearest, so the
    // nearest set bit after 'last' is the one left in 'res'.
    for (int i = MAX_REQ; i >= 1; i--) begin
      if (i <= n) begin
        k = last + i;
        if (k >= n) k = k - n;
        if (req[4'(k)]) res = k;
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin selector. Given the request vector
//               and the previous winner, returns the next winner and a valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ_p  = 4,
  parameter int ID_WIDTH_p = $clog2(NUM_REQ_p)
) (
  input  logic [NUM_REQ_p-1:0]  req,
  input  logic [ID_WIDTH_p-1:0] last,
  output logic [ID_WIDTH_p-1:0] idx,
  output logic                  valid
);

  logic [MAX_REQ-1:0] req_wide;
  int                 sel;

  // Widen the request vector and run the shared selection function.
  always_comb begin
    req_wide                  = '0;
    req_wide[NUM_REQ_p-1:0]   = req;
    sel                       = rr_next(req_wide, int'(last), NUM_REQ_p);
    valid                     = (sel >= 0);
    idx                       = ID_WIDTH_p'(sel);
  end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Round-robin write-side arbiter sharing one FIFO among
//               NUM_REQ_p producers with bounded bursts and owner tagging.
//               Never writes while the FIFO reports full.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ_p    = 4,
  parameter int DATA_WIDTH_p = 16,
  parameter int BURST_LEN_p  = 4,
  parameter int ID_WIDTH_p   = $clog2(NUM_REQ_p)
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             enable_i,
  input  logic [NUM_REQ_p-1:0]             req_i,
  input  logic [NUM_REQ_p*DATA_WIDTH_p-1:0] data_i,
  output logic [NUM_REQ_p-1:0]             ack_o,
  input  logic                             fifo_full_i,
  output logic                             fifo_write_o,
  output logic [ID_WIDTH_p+DATA_WIDTH_p-1:0] fifo_data_o,
  output logic [ID_WIDTH_p-1:0]            owner_o,
  output logic                             busy_o
);

  state_e                  state_q, state_d;
  logic [ID_WIDTH_p-1:0]   owner_q, owner_d;
  logic [ID_WIDTH_p-1:0]   last_owner_q, last_owner_d;
  logic [7:0]              burst_cnt_q, burst_cnt_d;

  logic [DATA_WIDTH_p-1:0] data_arr [NUM_REQ_p];
  logic [ID_WIDTH_p-1:0]   pick_idx;
  logic                    pick_valid;
  logic                    own_req;
  logic                    own_ack;

  // Split the flat producer bus into one word per producer.
  for (genvar k = 0; k < NUM_REQ_p; k++) begin : g_unpack
    assign data_arr[k] = data_i[k*DATA_WIDTH_p +: DATA_WIDTH_p];
  end

  rr_pick #(
    .NUM_REQ_p  (NUM_REQ_p),
    .ID_WIDTH_p (ID_WIDTH_p)
  ) u_rr_pick (
    .req   (req_i),
    .last  (last_owner_q),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign own_req     = req_i[owner_q];
  assign fifo_data_o = {owner_q, data_arr[owner_q]};
  assign owner_o     = owner_q;
  assign busy_o      = (state_q == ST_BUSY);

  // Next-state and output decode: grant in ARB, stream with stall in BUSY.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    ack_o        = '0;
    fifo_write_o = 1'b0;
    own_ack      = 1'b0;

    case (state_q)
      ST_ARB: begin
        if (enable_i && pick_valid) begin
          owner_d     = pick_idx;
          burst_cnt_d = 8'd0;
          state_d     = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A full FIFO with the owner still requesting simply stalls here.
        own_ack = own_req & ~fifo_full_i & enable_i;
        if (own_ack) begin
          ack_o[owner_q] = 1'b1;
          fifo_write_o   = 1'b1;
          burst_cnt_d    = burst_cnt_q + 8'd1;
        end
        if ((own_ack && ((burst_cnt_q + 8'd1) == 8'(BURST_LEN_p))) ||
            !own_req || !enable_i) begin
          state_d      = ST_ARB;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State registers; reset makes producer 0 the first winner.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ST_ARB;
      owner_q      <= '0;
      last_owner_q <= ID_WIDTH_p'(NUM_REQ_p - 1);
      burst_cnt_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Directed, table-driven bench for fifo_write_arbiter
//               (4 producers, 16-bit data, bursts of 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [3:0]  req;
  logic [63:0] data;
  logic [3:0]  ack;
  logic        full;
  logic        wr;
  logic [17:0] fdata;
  logic [1:0]  owner;
  logic        busy;

  int n_vec  = 0;
  int n_miss = 0;

  fifo_write_arbiter #(
    .NUM_REQ_p    (4),
    .DATA_WIDTH_p (16),
    .BURST_LEN_p  (4)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (en),
    .req_i        (req),
    .data_i       (data),
    .ack_o        (ack),
    .fifo_full_i  (full),
    .fifo_write_o (wr),
    .fifo_data_o  (fdata),
    .owner_o      (owner),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;   // pulse reset before applying this vector
    logic [3:0] req;
    logic       full;
    logic       en;
    logic [3:0] ack;   // expected
    logic       busy;  // expected
    logic [1:0] own;   // expected
  } vec_t;

  vec_t vt[$];

  function automatic void add(input logic r, input logic [3:0] q, input logic f,
                              input logic e, input logic [3:0] a, input logic b,
                              input logic [1:0] o);
    vec_t v;
    v.rst = r; v.req = q; v.full = f; v.en = e; v.ack = a; v.busy = b; v.own = o;
    vt.push_back(v);
  endfunction

  function automatic logic [17:0] exp_data(input logic [1:0] o);
    logic [15:0] w;
    case (o)
      2'd0:    w = 16'hA0A0;
      2'd1:    w = 16'hB1B1;
      2'd2:    w = 16'hC2C2;
      default: w = 16'hD3D3;
    endcase
    return {o, w};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] o;
    rst_n = 1'b0; en = 1'b0; req = 4'b0; full = 1'b0;
    data  = {16'hD3D3, 16'hC2C2, 16'hB1B1, 16'hA0A0};

    // Scenario 1: all request, never full. Owners 0,1,2,3,0; 4 acks + bubble.
    add(1, 4'hF, 0, 1, 4'h0, 0, 2'd0);
    for (int b = 0; b < 5; b++) begin
      o = 2'(b % 4);
      for (int w = 0; w < 4; w++) add(0, 4'hF, 0, 1, 4'(1 << o), 1, o);
      add(0, 4'hF, 0, 1, 4'h0, 0, o);
    end

    // Scenario 2: only producer 2, ten words -> bursts 4,4,2 then release.
    add(1, 4'b0100, 0, 1, 4'h0, 0, 2'd0);
    for (int w = 0; w < 4; w++) add(0, 4'b0100, 0, 1, 4'b0100, 1, 2'd2);
    add(0, 4'b0100, 0, 1, 4'h0, 0, 2'd2);
    for (int w = 0; w < 4; w++) add(0, 4'b0100, 0, 1, 4'b0100, 1, 2'd2);
    add(0, 4'b0100, 0, 1, 4'h0, 0, 2'd2);
    add(0, 4'b0100, 0, 1, 4'b0100, 1, 2'd2);
    add(0, 4'b0100, 0, 1, 4'b0100, 1, 2'd2);
    add(0, 4'b0000, 0, 1, 4'h0, 1, 2'd2);   // request gone: BUSY, no ack
    add(0, 4'b0000, 0, 1, 4'h0, 0, 2'd2);   // back to ARB, nothing to grant

    // Scenario 3: producer 1, FIFO full for 3 cycles after two words.
    add(1, 4'b0010, 0, 1, 4'h0, 0, 2'd0);
    add(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1);
    add(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1);
    for (int s = 0; s < 3; s++) add(0, 4'b0010, 1, 1, 4'h0, 1, 2'd1);
    add(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1);
    add(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1); // 4th word ends the burst
    add(0, 4'b0010, 0, 1, 4'h0, 0, 2'd1);
    add(0, 4'b0010, 0, 1, 4'b0010, 1, 2'd1);

    // Scenario 4: owner 0 drops after 2 words; next requester above it is 2.
    add(1, 4'hF, 0, 1, 4'h0, 0, 2'd0);
    add(0, 4'hF, 0, 1, 4'b0001, 1, 2'd0);
    add(0, 4'hF, 0, 1, 4'b0001, 1, 2'd0);
    add(0, 4'b1100, 0, 1, 4'h0, 1, 2'd0);
    add(0, 4'b1100, 0, 1, 4'h0, 0, 2'd0);
    add(0, 4'b1100, 0, 1, 4'b0100, 1, 2'd2);

    // Scenario 6: enable gating, including enable dropping mid-burst.
    add(1, 4'hF, 0, 0, 4'h0, 0, 2'd0);
    add(0, 4'hF, 0, 0, 4'h0, 0, 2'd0);
    add(0, 4'hF, 0, 0, 4'h0, 0, 2'd0);
    add(0, 4'hF, 0, 1, 4'h0, 0, 2'd0);
    add(0, 4'hF, 0, 1, 4'b0001, 1, 2'd0);
    add(0, 4'hF, 0, 0, 4'h0, 1, 2'd0);      // enable low: no ack, leave BUSY
    add(0, 4'hF, 0, 0, 4'h0, 0, 2'd0);
    add(0, 4'hF, 0, 0, 4'h0, 0, 2'd0);
    add(0, 4'hF, 0, 1, 4'h0, 0, 2'd0);
    add(0, 4'hF, 0, 1, 4'b0010, 1, 2'd1);   // resumes at last_owner+1

    for (int i = 0; i < vt.size(); i++) begin
      if (vt[i].rst) do_reset();
      req  = vt[i].req;
      full = vt[i].full;
      en   = vt[i].en;
      @(negedge clk);
      check($sformatf("v%0d ack", i),   32'(ack),   32'(vt[i].ack));
      check($sformatf("v%0d write", i), 32'(wr),    32'(|vt[i].ack));
      check($sformatf("v%0d busy", i),  32'(busy),  32'(vt[i].busy));
      check($sformatf("v%0d owner", i), 32'(owner), 32'(vt[i].own));
      check($sformatf("v%0d data", i),  32'(fdata), 32'(exp_data(vt[i].own)));
      @(posedge clk);
      #1;
    end

    // Asynchronous reset in the middle of producer 1's burst.
    req = 4'hF; full = 1'b0; en = 1'b1;
    do_reset();
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("prerst write", 32'(wr), 32'd1);
    check("prerst owner", 32'(owner), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst write", 32'(wr), 32'd0);
    check("rst ack", 32'(ack), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst owner", 32'(owner), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("postrst arb ack", 32'(ack), 32'd0);
    check("postrst arb busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("postrst ack", 32'(ack), 32'b0001);
    check("postrst owner", 32'(owner), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
